// File: rtl/module_dcf77_pulse_decoder.sv
// DCF77 pulse decoder: synchronise and debounce the receiver output, then
// turn pulse widths and gaps into bits, second strobes and minute sync.
module module_dcf77_pulse_decoder #(
    parameter int DEB_MS        = 4,
    parameter int MIN_PULSE_MS  = 40,
    parameter int BIT_THRESH_MS = 150,
    parameter int MAX_PULSE_MS  = 250,
    parameter int GAP_MS        = 1500,
    parameter int TIMEOUT_MS    = 2500
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       ms_tick,
    input  logic       dcf_in,
    output logic       sec_pulse,
    output logic       bit_valid,
    output logic       bit_value,
    output logic [5:0] bit_index,
    output logic       minute_sync,
    output logic       synced,
    output logic       signal_err
);

    localparam int DW = $clog2(DEB_MS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);
    localparam logic [11:0] MIN_W = 12'(MIN_PULSE_MS);
    localparam logic [11:0] THR_W = 12'(BIT_THRESH_MS);
    localparam logic [11:0] MAX_W = 12'(MAX_PULSE_MS);
    localparam logic [11:0] GAP_W = 12'(GAP_MS);
    localparam logic [11:0] TMO_W = 12'(TIMEOUT_MS);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LOST} state_t;

    state_t        state;
    logic          sync1, sync2;
    logic          filt, filt_d;
    logic [DW-1:0] deb_cnt;
    logic [11:0]   cnt;
    logic [11:0]   cnt_inc;
    logic          rise, fall;

    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= dcf_in;
            sync2 <= sync1;
        end
    end

    // Filter flips only after DEB_MS consecutive disagreeing ticks.
    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            filt    <= 1'b0;
            filt_d  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (ms_tick) begin
                if (sync2 != filt) begin
                    if (deb_cnt == DEB_LAST) begin
                        filt    <= sync2;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end else begin
                    deb_cnt <= '0;
                end
            end
        end
    end

    assign rise    = filt & ~filt_d;
    assign fall    = ~filt & filt_d;
    assign cnt_inc = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;

    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sec_pulse   <= 1'b0;
            bit_valid   <= 1'b0;
            bit_value   <= 1'b0;
            bit_index   <= '0;
            minute_sync <= 1'b0;
            synced      <= 1'b0;
            signal_err  <= 1'b0;
        end else begin
            sec_pulse   <= 1'b0;
            bit_valid   <= 1'b0;
            minute_sync <= 1'b0;
            unique case (state)
                IDLE, LOST: begin
                    if (rise) begin
                        state     <= HIGH;
                        sec_pulse <= 1'b1;
                        bit_index <= '0;
                        cnt       <= '0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        cnt   <= '0;
                        if (cnt >= MIN_W && cnt <= MAX_W) begin
                            bit_valid <= 1'b1;
                            bit_value <= (cnt >= THR_W);
                        end else begin
                            signal_err <= 1'b1;
                            synced     <= 1'b0;
                        end
                    end else if (rise) begin
                        cnt <= '0;
                    end else if (ms_tick) begin
                        if (cnt_inc >= TMO_W) begin
                            state      <= LOST;
                            cnt        <= '0;
                            synced     <= 1'b0;
                            signal_err <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        state     <= HIGH;
                        cnt       <= '0;
                        sec_pulse <= 1'b1;
                        if (cnt >= GAP_W) begin
                            minute_sync <= 1'b1;
                            bit_index   <= '0;
                            synced      <= 1'b1;
                            signal_err  <= 1'b0;
                        end else if (bit_index == 6'd58) begin
                            signal_err <= 1'b1;
                            synced     <= 1'b0;
                            bit_index  <= '0;
                        end else begin
                            bit_index <= bit_index + 6'd1;
                        end
                    end else if (fall) begin
                        cnt <= '0;
                    end else if (ms_tick) begin
                        if (cnt_inc >= TMO_W) begin
                            state      <= LOST;
                            cnt        <= '0;
                            synced     <= 1'b0;
                            signal_err <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_module_dcf77_pulse_decoder.sv
// Scoreboard bench for the DCF77 pulse decoder: a pulse/gap level model
// predicts each strobe, a monitor pops and compares them.
module tb_module_dcf77_pulse_decoder;

    typedef struct packed {
        logic       kind;
        logic       ms;
        logic       val;
        logic [5:0] idx;
        logic       syn;
        logic       err;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       ms_tick;
    logic       dcf_in;
    logic       sec_pulse;
    logic       bit_valid;
    logic       bit_value;
    logic [5:0] bit_index;
    logic       minute_sync;
    logic       synced;
    logic       signal_err;

    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t exp_q[$];

    bit running  = 0;
    int idx      = 0;
    bit synced_m = 0;
    bit err_m    = 0;
    int prev_gap = 0;

    module_dcf77_pulse_decoder dut (
        .qzt_clk     (clk),
        .reset       (reset),
        .ms_tick     (ms_tick),
        .dcf_in      (dcf_in),
        .sec_pulse   (sec_pulse),
        .bit_valid   (bit_valid),
        .bit_value   (bit_value),
        .bit_index   (bit_index),
        .minute_sync (minute_sync),
        .synced      (synced),
        .signal_err  (signal_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        ms_tick = 0;
        forever begin
            @(negedge clk);
            ms_tick = ~ms_tick;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && (sec_pulse || bit_valid)) begin
            ev_t act;
            ev_t want;
            n_tests++;
            if (sec_pulse && bit_valid) begin
                n_fail++;
                $display("FAIL strobe_excl: sec_pulse=%b bit_valid=%b want not both",
                         sec_pulse, bit_valid);
            end
            act = {bit_valid, minute_sync, bit_valid & bit_value,
                   bit_index, synced, signal_err};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got %b want none", act);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL event: got kind=%b ms=%b val=%b idx=%0d syn=%b err=%b want kind=%b ms=%b val=%b idx=%0d syn=%b err=%b",
                             act.kind, act.ms, act.val, act.idx, act.syn, act.err,
                             want.kind, want.ms, want.val, want.idx, want.syn, want.err);
                end
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (ms_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic m_rise();
        logic ms;
        ms = 1'b0;
        if (!running) begin
            running = 1;
            idx     = 0;
        end else if (prev_gap >= 1500) begin
            ms       = 1'b1;
            idx      = 0;
            synced_m = 1;
            err_m    = 0;
        end else if (idx == 58) begin
            err_m    = 1;
            synced_m = 0;
            idx      = 0;
        end else begin
            idx++;
        end
        exp_q.push_back({1'b0, ms, 1'b0, 6'(idx), synced_m, err_m});
    endtask

    task automatic m_fall(input int w);
        if (w >= 40 && w <= 250) begin
            exp_q.push_back({1'b1, 1'b0, 1'(w >= 150), 6'(idx), synced_m, err_m});
        end else begin
            err_m    = 1;
            synced_m = 0;
        end
    endtask

    task automatic m_low(input int g);
        prev_gap = g;
        if (g >= 2500) begin
            running  = 0;
            synced_m = 0;
            err_m    = 1;
        end
    endtask

    task automatic pulse(input int w, input int g, input bit glitch);
        m_rise();
        dcf_in = 1;
        ticks(w);
        m_fall(w);
        dcf_in = 0;
        if (glitch) begin
            ticks(g / 2);
            dcf_in = 1;
            ticks(2);
            dcf_in = 0;
            ticks(g - g / 2 - 2);
        end else begin
            ticks(g);
        end
        m_low(g);
    endtask

    task automatic check_zero(input string name);
        logic [11:0] outs;
        outs = {sec_pulse, bit_valid, bit_value, bit_index,
                minute_sync, synced, signal_err};
        n_tests++;
        if (outs !== 12'd0) begin
            n_fail++;
            $display("FAIL %s: got outputs %b want all 0", name, outs);
        end
    endtask

    task automatic do_reset(input string name);
        reset  = 0;
        dcf_in = 0;
        exp_q.delete();
        running  = 0;
        idx      = 0;
        synced_m = 0;
        err_m    = 0;
        prev_gap = 0;
        repeat (4) @(posedge clk);
        #1;
        check_zero(name);
        reset = 1;
    endtask

    int widths[10] = '{39, 40, 100, 149, 150, 200, 250, 251, 30, 300};

    initial begin
        reset  = 0;
        dcf_in = 0;
        do_reset("reset_state");
        ticks(20);

        pulse(100, 400, 0);
        pulse(200, 400, 0);
        pulse(149, 400, 0);
        pulse(150, 400, 1);
        pulse(30, 400, 1);
        pulse(300, 400, 0);

        pulse(100, 1800, 0);
        repeat (59) pulse(100, 60, 0);
        pulse(100, 2700, 0);
        pulse(100, 300, 0);

        for (int i = 0; i < 12; i++) begin
            int w;
            int g;
            bit gl;
            w  = widths[$urandom_range(0, 9)];
            g  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1600, 1900))
                                             : int'($urandom_range(60, 300));
            gl = ($urandom_range(0, 3) == 0);
            pulse(w, g, gl);
        end

        m_rise();
        dcf_in = 1;
        ticks(50);
        do_reset("reset_mid_high");
        ticks(300);
        pulse(100, 200, 0);
        ticks(50);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: got %0d pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
